// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: controller/datapath signal bundle, master = controller, slave = datapath
interface multicycle_ctrl_if;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       pcen;
   logic       irwrite;
   logic       memwrite;
   logic       regwrite;
   logic       iord;
   logic       memtoreg;
   logic       regdst;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [1:0] pcsrc;
   logic [2:0] alucontrol;
   logic [3:0] state;
   modport master (
      input  op, funct, zero, mem_ready,
      output pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca,
             alusrcb, pcsrc, alucontrol, state
   );
   modport slave (
      output op, funct, zero, mem_ready,
      input  pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca,
             alusrcb, pcsrc, alucontrol, state
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle MIPS main control FSM; define MC_BNE_EN to add bne
module multicycle_ctrl (
   input logic             clk,
   input logic             reset,
   multicycle_ctrl_if.master bus
);
   typedef enum logic [3:0] {
      FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
      EXECUTE = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, ADDIEX = 4'd9, ADDIWB = 4'd10, JUMP = 4'd11
   } state_t;
   state_t st, nx;
   logic       bne, legal;
   logic [2:0] aluf;
`ifdef MC_BNE_EN
   assign bne = bus.op == 6'b000101;
`else
   assign bne = 1'b0;
`endif
   assign legal = bus.funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
   assign aluf  = bus.funct == 6'b100010 ? 3'b110 :
                  bus.funct == 6'b100100 ? 3'b000 :
                  bus.funct == 6'b100101 ? 3'b001 :
                  bus.funct == 6'b101010 ? 3'b111 : 3'b010;
   assign bus.state = st;
   // state register; reset aborts the current instruction immediately
   always_ff @(posedge clk or posedge reset)
      if (reset) st <= FETCH;
      else st <= nx;
   // next-state and per-state control decode
   always_comb begin
      nx             = FETCH;
      bus.pcen       = 1'b0;
      bus.irwrite    = 1'b0;
      bus.memwrite   = 1'b0;
      bus.regwrite   = 1'b0;
      bus.iord       = 1'b0;
      bus.memtoreg   = 1'b0;
      bus.regdst     = 1'b0;
      bus.alusrca    = 1'b0;
      bus.alusrcb    = 2'b00;
      bus.pcsrc      = 2'b00;
      bus.alucontrol = 3'b000;
      case (st)
         FETCH: begin
            bus.alusrcb    = 2'b01;
            bus.alucontrol = 3'b010;
            bus.irwrite    = bus.mem_ready;
            bus.pcen       = bus.mem_ready;
            nx             = bus.mem_ready ? DECODE : FETCH;
         end
         DECODE: begin
            bus.alusrcb    = 2'b11;
            bus.alucontrol = 3'b010;
            nx = (bus.op == 6'b100011 || bus.op == 6'b101011) ? MEMADR :
                 bus.op == 6'b000000                          ? EXECUTE :
                 (bus.op == 6'b000100 || bne)                 ? BRANCH :
                 bus.op == 6'b001000                          ? ADDIEX :
                 bus.op == 6'b000010                          ? JUMP : FETCH;
         end
         MEMADR: begin
            bus.alusrca    = 1'b1;
            bus.alusrcb    = 2'b10;
            bus.alucontrol = 3'b010;
            nx             = bus.op == 6'b101011 ? MEMWR : MEMRD;
         end
         MEMRD: begin
            bus.iord = 1'b1;
            nx       = bus.mem_ready ? MEMWB : MEMRD;
         end
         MEMWB: begin
            bus.memtoreg = 1'b1;
            bus.regwrite = 1'b1;
         end
         MEMWR: begin
            bus.iord     = 1'b1;
            bus.memwrite = 1'b1;
            nx           = bus.mem_ready ? FETCH : MEMWR;
         end
         EXECUTE: begin
            bus.alusrca    = 1'b1;
            bus.alucontrol = aluf;
            nx             = ALUWB;
         end
         ALUWB: begin
            bus.regdst   = legal;
            bus.regwrite = legal;
         end
         BRANCH: begin
            bus.alusrca    = 1'b1;
            bus.alucontrol = 3'b110;
            bus.pcsrc      = 2'b01;
            bus.pcen       = bne ? ~bus.zero : bus.zero;
         end
         ADDIEX: begin
            bus.alusrca    = 1'b1;
            bus.alusrcb    = 2'b10;
            bus.alucontrol = 3'b010;
            nx             = ADDIWB;
         end
         ADDIWB: bus.regwrite = 1'b1;
         JUMP: begin
            bus.pcsrc = 2'b10;
            bus.pcen  = 1'b1;
         end
         default: nx = FETCH;
      endcase
   end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: instruction-level reference model checks of multicycle_ctrl
module tb_multicycle_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   compared = 0;
   int   mismatched = 0;
   multicycle_ctrl_if bus();
   multicycle_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;

   localparam logic [7:0] PCEN = 8'h80, IRW = 8'h40, MW = 8'h20, RW = 8'h10;
   localparam logic [7:0] IORD = 8'h08, M2R = 8'h04, RD = 8'h02, SA = 8'h01;

   typedef struct {
      logic        mr;
      logic        load;
      logic [18:0] exp;
   } step_t;

   // expected vector: {pcen..alusrca, alusrcb, pcsrc, alucontrol, state}
   function automatic logic [18:0] v(int s, logic [7:0] en, logic [1:0] b, logic [1:0] p, logic [2:0] a);
      logic [3:0] s4;
      s4 = s[3:0];
      return {en, b, p, a, s4};
   endfunction

   function automatic logic [18:0] obs();
      return {bus.pcen, bus.irwrite, bus.memwrite, bus.regwrite, bus.iord, bus.memtoreg,
              bus.regdst, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.alucontrol, bus.state};
   endfunction

   task automatic chk(string tag, logic [18:0] got, logic [18:0] exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // one instruction: fetch waits, op/funct load, then the per-class step list from the ISA rules
   task automatic run_instr(string tag, logic [5:0] op, logic [5:0] funct, logic z,
                            int wf, int wm, int abort_at);
      step_t q[$];
      logic [2:0] af;
      logic legal, bne_op, take;
      for (int i = 0; i < wf; i++) q.push_back('{1'b0, 1'b0, v(0, 0, 2'b01, 2'b00, 3'b010)});
      q.push_back('{1'b1, 1'b1, v(0, PCEN | IRW, 2'b01, 2'b00, 3'b010)});
      q.push_back('{1'($urandom), 1'b0, v(1, 0, 2'b11, 2'b00, 3'b010)});
`ifdef MC_BNE_EN
      bne_op = op == 6'b000101;
`else
      bne_op = 1'b0;
`endif
      case (funct)
         6'b100000: begin af = 3'b010; legal = 1'b1; end
         6'b100010: begin af = 3'b110; legal = 1'b1; end
         6'b100100: begin af = 3'b000; legal = 1'b1; end
         6'b100101: begin af = 3'b001; legal = 1'b1; end
         6'b101010: begin af = 3'b111; legal = 1'b1; end
         default:   begin af = 3'b010; legal = 1'b0; end
      endcase
      if (op == 6'b100011 || op == 6'b101011) begin
         q.push_back('{1'($urandom), 1'b0, v(2, SA, 2'b10, 2'b00, 3'b010)});
         if (op == 6'b100011) begin
            for (int i = 0; i < wm; i++) q.push_back('{1'b0, 1'b0, v(3, IORD, 0, 0, 0)});
            q.push_back('{1'b1, 1'b0, v(3, IORD, 0, 0, 0)});
            q.push_back('{1'($urandom), 1'b0, v(4, M2R | RW, 0, 0, 0)});
         end else begin
            for (int i = 0; i < wm; i++) q.push_back('{1'b0, 1'b0, v(5, IORD | MW, 0, 0, 0)});
            q.push_back('{1'b1, 1'b0, v(5, IORD | MW, 0, 0, 0)});
         end
      end else if (op == 6'b000000) begin
         q.push_back('{1'($urandom), 1'b0, v(6, SA, 2'b00, 2'b00, af)});
         q.push_back('{1'($urandom), 1'b0, v(7, legal ? (RD | RW) : 8'h00, 0, 0, 0)});
      end else if (op == 6'b000100 || bne_op) begin
         take = bne_op ? ~z : z;
         q.push_back('{1'($urandom), 1'b0, v(8, SA | (take ? PCEN : 8'h00), 2'b00, 2'b01, 3'b110)});
      end else if (op == 6'b001000) begin
         q.push_back('{1'($urandom), 1'b0, v(9, SA, 2'b10, 2'b00, 3'b010)});
         q.push_back('{1'($urandom), 1'b0, v(10, RW, 0, 0, 0)});
      end else if (op == 6'b000010) begin
         q.push_back('{1'($urandom), 1'b0, v(11, PCEN, 2'b00, 2'b10, 3'b000)});
      end
      foreach (q[i]) begin
         bus.mem_ready = q[i].mr;
         bus.zero = z;
         if (q[i].load) begin
            bus.op = op;
            bus.funct = funct;
         end
         #1 chk($sformatf("%s step %0d", tag, i), obs(), q[i].exp);
         if (i == abort_at) begin
            bus.mem_ready = 1'b1;
            #1 reset = 1'b1;
            #1 chk({tag, " async reset"}, obs(), v(0, PCEN | IRW, 2'b01, 2'b00, 3'b010));
            bus.mem_ready = 1'b0;
            #1 reset = 1'b0;
            @(negedge clk);
            return;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      logic [5:0] ops[8];
      logic [5:0] fs[6];
      logic [5:0] op, fn;
      ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b000101, 6'b111111};
      fs  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
      bus.op = 6'b0;
      bus.funct = 6'b0;
      bus.zero = 1'b0;
      bus.mem_ready = 1'b1;
      #2 chk("reset mr=1", obs(), v(0, PCEN | IRW, 2'b01, 2'b00, 3'b010));
      bus.mem_ready = 1'b0;
      #1 chk("reset mr=0", obs(), v(0, 0, 2'b01, 2'b00, 3'b010));
      @(posedge clk);
      #1 chk("reset held", obs(), v(0, 0, 2'b01, 2'b00, 3'b010));
      @(negedge clk);
      reset = 1'b0;
      run_instr("lw", 6'b100011, 6'b0, 1'b0, 0, 0, -1);
      run_instr("sw wait2", 6'b101011, 6'b0, 1'b0, 0, 2, -1);
      run_instr("rtype slt", 6'b000000, 6'b101010, 1'b0, 0, 0, -1);
      run_instr("rtype bad funct", 6'b000000, 6'b000111, 1'b0, 0, 0, -1);
      run_instr("beq taken", 6'b000100, 6'b0, 1'b1, 0, 0, -1);
      run_instr("beq not taken", 6'b000100, 6'b0, 1'b0, 0, 0, -1);
      run_instr("j", 6'b000010, 6'b0, 1'b0, 0, 0, -1);
      run_instr("op 000101", 6'b000101, 6'b0, 1'b0, 0, 0, -1);
      run_instr("addi", 6'b001000, 6'b0, 1'b0, 1, 0, -1);
      run_instr("reset mid exec", 6'b000000, 6'b100000, 1'b0, 0, 0, 2);
      run_instr("after reset", 6'b000000, 6'b100010, 1'b0, 0, 0, -1);
      run_instr("lw waits", 6'b100011, 6'b0, 1'b1, 2, 3, -1);
      for (int n = 0; n < 60; n++) begin
         op = $urandom_range(0, 1) ? ops[$urandom_range(0, 7)] : 6'($urandom);
         fn = $urandom_range(0, 1) ? fs[$urandom_range(0, 5)] : 6'($urandom);
         run_instr($sformatf("rand %0d op %b fn %b", n, op, fn), op, fn, 1'($urandom),
                   $urandom_range(0, 2), $urandom_range(0, 2), -1);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
